// File: rtl/i_fetch_queue_if.sv
`default_nettype none
// +------------------------------------------------------------------+
// | i_fetch_queue_if : cache / redirect / dispatch bundle of the IFQ  |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
interface i_fetch_queue_if #(
  parameter int DATA_WIDTH       = 32,
  parameter int CACHE_LINE_WIDTH = 128
);
  logic [DATA_WIDTH-1:0]       cache_pc;
  logic                        cache_rd_en;
  logic                        cache_abort;
  logic [CACHE_LINE_WIDTH-1:0] cache_line;
  logic                        cache_line_valid;
  logic                        jmp_br_valid;
  logic [DATA_WIDTH-1:0]       jmp_br_addr;
  logic                        disp_rd_en;
  logic [DATA_WIDTH-1:0]       instr;
  logic [DATA_WIDTH-1:0]       instr_pc;
  logic [DATA_WIDTH-1:0]       instr_pc_plus4;
  logic                        empty;
  logic [31:0]                 stall_cnt;

  modport master (
    output cache_pc, cache_rd_en, cache_abort,
    output instr, instr_pc, instr_pc_plus4, empty, stall_cnt,
    input  cache_line, cache_line_valid, jmp_br_valid, jmp_br_addr, disp_rd_en
  );

  modport slave (
    input  cache_pc, cache_rd_en, cache_abort,
    input  instr, instr_pc, instr_pc_plus4, empty, stall_cnt,
    output cache_line, cache_line_valid, jmp_br_valid, jmp_br_addr, disp_rd_en
  );
endinterface
`default_nettype wire

// File: rtl/i_fetch_queue.sv
`default_nettype none
// +------------------------------------------------------------------+
// | i_fetch_queue : line-buffered instruction fetch queue with        |
// | redirect; optional empty-cycle counter under IFQ_STALL_CNT_EN     |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
module i_fetch_queue #(
  parameter int DATA_WIDTH       = 32,
  parameter int CACHE_LINE_WIDTH = 128,
  parameter int DEPTH            = 4
) (
  input  wire logic       clk,
  input  wire logic       rst,
  i_fetch_queue_if.master bus_io
);
  localparam int c_WORDS  = CACHE_LINE_WIDTH / DATA_WIDTH;
  localparam int c_WSEL_W = $clog2(c_WORDS);
  localparam int c_WB_W   = $clog2(DATA_WIDTH / 8);
  localparam int c_OFF_W  = $clog2(CACHE_LINE_WIDTH / 8);
  localparam int c_PTR_W  = $clog2(DEPTH);
  localparam int c_CNT_W  = $clog2(DEPTH + 1);

  localparam logic [DATA_WIDTH-1:0] c_LINE_BYTES = DATA_WIDTH'(CACHE_LINE_WIDTH / 8);
  localparam logic [DATA_WIDTH-1:0] c_WORD_BYTES = DATA_WIDTH'(DATA_WIDTH / 8);
  localparam logic [c_CNT_W-1:0]    c_FULL       = c_CNT_W'(DEPTH);
  localparam logic [c_WSEL_W-1:0]   c_LAST_WORD  = c_WSEL_W'(c_WORDS - 1);

  logic [CACHE_LINE_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0]       fetch_pc_q, fetch_pc_d;
  logic [DATA_WIDTH-1:0]       disp_pc_q, disp_pc_d;
  logic [c_PTR_W-1:0]          wr_ptr_q, wr_ptr_d;
  logic [c_PTR_W-1:0]          rd_ptr_q, rd_ptr_d;
  logic [c_CNT_W-1:0]          count_q, count_d;
  logic [c_WSEL_W-1:0]         word_sel_q, word_sel_d;

  logic                        w_full;
  logic                        w_empty;
  logic                        w_rd_en;
  logic                        w_write;
  logic                        w_pop;
  logic                        w_line_pop;
  logic [CACHE_LINE_WIDTH-1:0] w_head_line;
  logic                        w_unused_addr_lsb;

  // Full is judged on the registered count, so a same-cycle pop never frees a slot.
  assign w_full     = (count_q == c_FULL);
  assign w_empty    = (count_q == '0);
  assign w_rd_en    = !rst && !bus_io.jmp_br_valid && !w_full;
  assign w_write    = w_rd_en && bus_io.cache_line_valid;
  assign w_pop      = bus_io.disp_rd_en && !w_empty && !bus_io.jmp_br_valid;
  assign w_line_pop = w_pop && (word_sel_q == c_LAST_WORD);

  assign w_unused_addr_lsb = ^bus_io.jmp_br_addr[c_WB_W-1:0];

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    disp_pc_d  = disp_pc_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    word_sel_d = word_sel_q;
    if (bus_io.jmp_br_valid) begin
      fetch_pc_d = {bus_io.jmp_br_addr[DATA_WIDTH-1:c_OFF_W], c_OFF_W'(0)};
      disp_pc_d  = bus_io.jmp_br_addr;
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      count_d    = '0;
      word_sel_d = bus_io.jmp_br_addr[c_OFF_W-1:c_WB_W];
    end else begin
      if (w_write) begin
        wr_ptr_d   = wr_ptr_q + c_PTR_W'(1);
        fetch_pc_d = fetch_pc_q + c_LINE_BYTES;
      end
      if (w_pop) begin
        disp_pc_d = disp_pc_q + c_WORD_BYTES;
        if (w_line_pop) begin
          word_sel_d = '0;
          rd_ptr_d   = rd_ptr_q + c_PTR_W'(1);
        end else begin
          word_sel_d = word_sel_q + c_WSEL_W'(1);
        end
      end
      case ({w_write, w_line_pop})
        2'b10:   count_d = count_q + c_CNT_W'(1);
        2'b01:   count_d = count_q - c_CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc_q <= '0;
      disp_pc_q  <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      word_sel_q <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      disp_pc_q  <= disp_pc_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      word_sel_q <= word_sel_d;
    end
  end

  always_ff @(posedge clk) begin
    if (w_write) begin
      mem_q[wr_ptr_q] <= bus_io.cache_line;
    end
  end

  assign w_head_line           = mem_q[rd_ptr_q];
  assign bus_io.cache_pc       = fetch_pc_q;
  assign bus_io.cache_rd_en    = w_rd_en;
  assign bus_io.cache_abort    = !rst && bus_io.jmp_br_valid;
  assign bus_io.instr          = w_head_line[word_sel_q*DATA_WIDTH +: DATA_WIDTH];
  assign bus_io.instr_pc       = disp_pc_q;
  assign bus_io.instr_pc_plus4 = disp_pc_q + c_WORD_BYTES;
  assign bus_io.empty          = w_empty;

`ifdef IFQ_STALL_CNT_EN
  logic [31:0] stall_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q <= '0;
    end else if (w_empty && (stall_cnt_q != 32'hFFFF_FFFF)) begin
      stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end

  assign bus_io.stall_cnt = stall_cnt_q;
`else
  assign bus_io.stall_cnt = 32'd0;
`endif

endmodule
`default_nettype wire

// File: doc/i_fetch_queue.md
# i_fetch_queue

Instruction fetch queue (IFQ) sitting directly downstream of the instruction cache and upstream of dispatch. It drives the cache with a 16-byte-aligned fetch PC and buffers returned 128-bit cache lines in a small FIFO. It hands one 32-bit instruction per cycle, with its PC, to dispatch. Taken jumps and branches flush the queue and redirect fetch.

## Interface
Parameters:
- DATA_WIDTH, 32, instruction/PC width
- CACHE_LINE_WIDTH, 128, cache line width (4 instructions)
- DEPTH, 4, FIFO depth in cache lines (power of 2)

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- cache_pc  out  DATA_WIDTH  fetch PC to cache, bits [3:0] always 0
- cache_rd_en  out  1  cache read request
- cache_abort  out  1  kill current cache read
- cache_line  in  CACHE_LINE_WIDTH  line from cache, word 0 in bits [31:0]
- cache_line_valid  in  1  cache_line valid this cycle
- jmp_br_valid  in  1  taken jump/branch redirect
- jmp_br_addr  in  DATA_WIDTH  redirect target (word aligned)
- disp_rd_en  in  1  dispatch consumes current instruction
- instr  out  DATA_WIDTH  head instruction
- instr_pc  out  DATA_WIDTH  PC of instr
- instr_pc_plus4  out  DATA_WIDTH  instr_pc + 4
- empty  out  1  no valid instruction at head
- stall_cnt  out  32  empty-cycle counter (only with IFQ_STALL_CNT_EN)

## Operation
- State: fetch_pc (line aligned), FIFO of DEPTH lines, wr_ptr/rd_ptr, count (0..DEPTH), word_sel (2 b), disp_pc.
- Fetch: cache_rd_en = !rst && !jmp_br_valid && (count != DEPTH); cache_pc = fetch_pc; cache_abort = jmp_br_valid.
- Write: if cache_rd_en && cache_line_valid, write line at wr_ptr, wr_ptr++, fetch_pc += 16.
- Read: instr = FIFO[rd_ptr] word word_sel; instr_pc = disp_pc; empty = (count == 0).
- Pop: if disp_rd_en && !empty, disp_pc += 4. If word_sel == 3, then rd_ptr++, count--, word_sel = 0; otherwise word_sel++.
- Simultaneous write and line pop: count unchanged. disp_rd_en while empty is ignored.
- Full: with count == DEPTH there are no requests. A pop in the same cycle does not enable a write; full is evaluated on the registered count.
- Redirect (highest priority over write/pop): count = 0, wr_ptr = rd_ptr = 0, fetch_pc = {jmp_br_addr[31:4], 4'h0}, word_sel = jmp_br_addr[3:2], disp_pc = jmp_br_addr.
- Pointers wrap modulo DEPTH. fetch_pc wraps modulo 2^32.

## Timing
- Reset values: fetch_pc=0, count=0, pointers=0, word_sel=0, disp_pc=0, empty=1, cache_rd_en=0, cache_abort=0, instr_pc_plus4=4, stall_cnt=0.
- Cache is combinational: line written at the end of the same cycle rd_en is high.
- Fetch-to-dispatch latency: 1 cycle (line written at edge N, empty=0 in cycle N+1).
- Redirect in cycle N: fetch of the target line in N+1, target instruction visible (empty=0) in N+2.
- Redirect during reset: reset wins.
- Steady state: 1 instruction/cycle sustained with DEPTH ≥ 2.

## Configuration
- IFQ_STALL_CNT_EN defined: stall_cnt increments (saturating at 0xFFFFFFFF) each cycle with empty=1 and rst=0. It clears on rst.
- Not defined: stall_cnt port tied to 0 and the counter logic is absent.

## Test plan
- Reset, cache returns lines with words 0x11,0x22,0x33,0x44 at PC 0, disp_rd_en=1 continuously -> cycle 2 onward instr=0x11,0x22,0x33,0x44 with instr_pc 0,4,8,0xC; cache_pc steps 0x0,0x10,0x20.
- disp_rd_en=0 with cache always valid -> after 4 writes count=4, cache_rd_en=0, cache_pc held at 0x40, empty=0, instr=0x11.
- Redirect jmp_br_addr=0x24 while queue full -> next cycle cache_abort low, cache_rd_en=1, cache_pc=0x20; following cycle instr = word 1 of line 0x20, instr_pc=0x24, instr_pc_plus4=0x28.
- Redirect asserted with disp_rd_en and cache_line_valid the same cycle -> no write or pop occurs, count=0, disp_pc=target.
- rst pulsed mid-stream with 3 lines queued -> next cycle empty=1, cache_pc=0, instr_pc=0, stall_cnt=0.
- With IFQ_STALL_CNT_EN, cache_line_valid held low 10 cycles after reset -> stall_cnt=10; without the macro stall_cnt=0.
